// File: rtl/seq_gen_moore.sv
// seq_gen_moore: Moore serial pattern generator. Shifts a PAT_W-bit pattern
// out MSB-first, rpt times, with GAP idle cycles between repetitions.
// Optional feature macro: SEQ_GEN_LOOP_EN (adds stop port, rpt=0 = endless).
// Ports:
//   clk, rst_n         clock (rising) / async active-low reset
//   start              request, accepted only in IDLE
//   pattern [PAT_W]    pattern latched with start, MSB sent first
//   rpt [CNT_W]        repetition count latched with start
//   stop               (SEQ_GEN_LOOP_EN only) finish current rep then end
//   dout, dout_vld     serial bit and its qualifier (dout=0 when not valid)
//   busy               high in every state but IDLE
//   done               one-cycle pulse after the last bit
module seq_gen_moore #(
    parameter int PAT_W = 4,
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rpt,
`ifdef SEQ_GEN_LOOP_EN
    input  logic             stop,
`endif
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BIT_LD = BW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LD = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GAP_S = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic [GW-1:0]    gap_cnt;

    logic             stop_now;
    logic             last_rep;
    logic [CNT_W-1:0] rep_load;

`ifdef SEQ_GEN_LOOP_EN
    logic stop_q;

    // A stop seen at any point of the transfer is remembered so the
    // decision at the end of the repetition still honours it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q <= 1'b0;
        end else if (state == IDLE) begin
            stop_q <= 1'b0;
        end else if ((state == SEND || state == GAP_S) && stop) begin
            stop_q <= 1'b1;
        end
    end

    always_comb begin
        stop_now = stop_q | (stop & (state == SEND || state == GAP_S));
        // rep_cnt == 0 encodes an endless run
        last_rep = stop_now | (rep_cnt == ONE);
        rep_load = rpt;
    end
`else
    always_comb begin
        stop_now = 1'b0;
        last_rep = (rep_cnt == ONE);
        rep_load = (rpt == '0) ? ONE : rpt;
    end
`endif

    // Outputs are registered with the values that belong to the state
    // being entered, so they change only on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            gap_cnt  <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= SEND;
                        shreg    <= pattern;
                        bit_cnt  <= BIT_LD;
                        rep_cnt  <= rep_load;
                        dout     <= pattern[PAT_W-1];
                        dout_vld <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        dout     <= 1'b0;
                        dout_vld <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_cnt != '0) begin
                        bit_cnt  <= bit_cnt - 1'b1;
                        dout     <= shreg[bit_cnt - 1'b1];
                        dout_vld <= 1'b1;
                    end else if (last_rep) begin
                        state    <= DONE;
                        dout     <= 1'b0;
                        dout_vld <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - ONE;
                        end
                        bit_cnt <= BIT_LD;
                        if (GAP > 0) begin
                            state    <= GAP_S;
                            gap_cnt  <= GAP_LD;
                            dout     <= 1'b0;
                            dout_vld <= 1'b0;
                        end else begin
                            dout     <= shreg[PAT_W-1];
                            dout_vld <= 1'b1;
                        end
                    end
                end
                GAP_S: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (stop_now) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= SEND;
                        dout     <= shreg[PAT_W-1];
                        dout_vld <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    dout     <= 1'b0;
                    dout_vld <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    dout     <= 1'b0;
                    dout_vld <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_moore.sv
// tb_seq_gen_moore: table vectors plus random transfers checked against an
// arithmetic model, on two instances (GAP=0 and GAP=2).
module tb_seq_gen_moore;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] rpt;
`ifdef SEQ_GEN_LOOP_EN
    logic       stop;
`endif
    logic d0, v0, b0, n0;
    logic d2, v2, b2, n2;

    int checks = 0;
    int errors = 0;

    seq_gen_moore #(.PAT_W(4), .GAP(0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pattern(pattern), .rpt(rpt),
`ifdef SEQ_GEN_LOOP_EN
        .stop(stop),
`endif
        .dout(d0), .dout_vld(v0), .busy(b0), .done(n0)
    );

    seq_gen_moore #(.PAT_W(4), .GAP(2), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pattern(pattern), .rpt(rpt),
`ifdef SEQ_GEN_LOOP_EN
        .stop(stop),
`endif
        .dout(d2), .dout_vld(v2), .busy(b2), .done(n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic [7:0]  rpt;
        logic [15:0] bits;
        int          n;
        int          glitch;
    } vec_t;

    vec_t tab [6];

    // Expected {dout,vld,busy,done} i cycles after the start edge.
    function automatic logic [3:0] model(input logic [3:0] pat,
                                         input int reps, input int gap,
                                         input int i);
        int total;
        int pos;
        total = reps * 4 + (reps - 1) * gap;
        if (i < total) begin
            pos = i % (4 + gap);
            if (pos < 4) return {pat[3 - pos], 1'b1, 1'b1, 1'b0};
            return 4'b0010;
        end
        if (i == total) return 4'b0011;
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got {dout,vld,busy,done}=%b expected %b",
                     name, idx, got, exp);
        end
    endtask

    task automatic run_txn(input logic [3:0] pat, input logic [7:0] r,
                           input int glitch, input bit use_tab,
                           input logic [15:0] bits, input int n);
        int reps;
        int last;
        logic [3:0] e0;
        reps = (r == 0) ? 1 : int'(r);
        last = reps * 4 + (reps - 1) * 2 + 1;
        pattern = pat;
        rpt = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pattern = 4'($urandom);
        rpt = 8'($urandom);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (use_tab) begin
                if (i < n) e0 = {bits[n - 1 - i], 3'b110};
                else if (i == n) e0 = 4'b0011;
                else e0 = 4'b0000;
            end else begin
                e0 = model(pat, reps, 0, i);
            end
            chk("gap0", i, {d0, v0, b0, n0}, e0);
            chk("gap2", i, {d2, v2, b2, n2}, model(pat, reps, 2, i));
            if (i + 1 == glitch) begin
                start = 1'b1;
                pattern = 4'b0000;
                rpt = 8'd1;
            end else begin
                start = 1'b0;
                pattern = 4'($urandom);
                rpt = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        tab[0] = '{4'b1101, 8'd1, 16'b1101, 4, -1};
        tab[1] = '{4'b1101, 8'd3, 16'b110111011101, 12, -1};
        tab[2] = '{4'b1101, 8'd2, 16'b11011101, 8, -1};
        tab[3] = '{4'b1101, 8'd1, 16'b1101, 4, 2};
        tab[4] = '{4'b1011, 8'd0, 16'b1011, 4, -1};
        tab[5] = '{4'b0110, 8'd2, 16'b01100110, 8, 3};

        rst_n = 1'b0;
        start = 1'b0;
        pattern = 4'b0;
        rpt = 8'd0;
`ifdef SEQ_GEN_LOOP_EN
        stop = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset0", 0, {d0, v0, b0, n0}, 4'b0000);
        chk("reset2", 0, {d2, v2, b2, n2}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle0", 0, {d0, v0, b0, n0}, 4'b0000);

        for (int t = 0; t < 6; t++) begin
            run_txn(tab[t].pat, tab[t].rpt, tab[t].glitch, 1'b1,
                    tab[t].bits, tab[t].n);
        end

        // Asynchronous reset two bits into a transfer.
        pattern = 4'b1101;
        rpt = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pre_rst0", i, {d0, v0, b0, n0}, model(4'b1101, 3, 0, i));
            chk("pre_rst2", i, {d2, v2, b2, n2}, model(4'b1101, 3, 2, i));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst0", 0, {d0, v0, b0, n0}, 4'b0000);
        chk("async_rst2", 0, {d2, v2, b2, n2}, 4'b0000);
        @(posedge clk);
        #1;
        chk("held_rst0", 0, {d0, v0, b0, n0}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(4'b1011, 8'd1, -1, 1'b1, 16'b1011, 4);

        for (int t = 0; t < 30; t++) begin
            int idle;
            int g;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                @(negedge clk);
                chk("rnd_idle0", k, {d0, v0, b0, n0}, 4'b0000);
                chk("rnd_idle2", k, {d2, v2, b2, n2}, 4'b0000);
            end
            g = $urandom_range(0, 4);
            run_txn(4'($urandom), 8'($urandom_range(0, 3)),
                    (g == 0) ? -1 : g, 1'b0, 16'd0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
